rr_priority_encoder: RTL and testbench
======================================

// Module: rr_priority_encoder
// PURPOSE
//  Registered, parametrised priority encoder / request picker. Each enabled cycle it
//  selects one set bit of a WIDTH-bit request vector and registers its index plus a valid flag.
//  Selection is fixed-priority or round-robin, chosen by a mode input.
//  A saturating counter tracks grants. Generalises the 4-bit, 3-bit-output example blocks in ch3.
// PARAMETERS
//  WIDTH  4  number of request lines; >= 2, need not be a power of two
//  CNT_W  8  width of grant counter
//  (derived) IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous reset, active-high
//  en         in   1      evaluate req this cycle; 0 = hold all state
//  mode       in   1      0 = fixed priority, 1 = round-robin
//  clr        in   1      synchronous clear of all state
//  req        in   WIDTH  request vector
//  idx        out  IDX_W  index of last granted request (registered)
//  valid      out  1      1 = idx updated by a grant on the last enabled edge
//  grant_cnt  out  CNT_W  number of grants since reset/clr, saturating
// BEHAVIOUR
//  - Reset (rst=1, async, effective immediately): idx=0, valid=0, ptr=0, grant_cnt=0.
//    Assertion mid-operation discards any in-flight decision. Release is sampled at the next edge.
//  - Latency: one clock. req is sampled at edge k and the result is visible after edge k.
//  - Edge priority: rst > clr > en. clr=1 forces idx=0, valid=0, ptr=0, grant_cnt=0,
//    regardless of en and req.
//  - en=0 (and clr=0): idx, valid, ptr and grant_cnt all hold.
//  - en=1, req==0: valid<=0; idx, ptr and grant_cnt hold.
//  - en=1, req!=0, mode=0 (fixed): winner = highest set index. valid<=1, idx<=winner.
//    ptr holds.
//  - en=1, req!=0, mode=1 (RR): winner = first set bit found by scanning upward from ptr,
//    wrapping WIDTH-1 -> 0. valid<=1, idx<=winner, ptr<=(winner==WIDTH-1) ? 0 : winner+1.
//    Wrap is explicit; it does not rely on power-of-two overflow.
//  - grant_cnt: +1 on every edge with en=1, clr=0 and req!=0. Holds at 2^CNT_W-1 once reached.
//  - A mode change takes effect on the same edge. ptr is preserved across mode changes.
//  - Internal state: ptr [IDX_W-1:0], always in range 0..WIDTH-1.
//  - All outputs come directly from flops; there is no combinational path from inputs to outputs.
// STRUCTURE
//  - Package rr_enc_pkg:
//      typedef enum logic {MODE_FIXED=1'b0, MODE_RR=1'b1} mode_e;
//      function clog2_min1(int) for IDX_W.
//  - Sub-module rr_pick, purely combinational: inputs req, ptr, mode; outputs winner[IDX_W-1:0]
//    and any. Implemented as masked two-pass search:
//      pass 1 over req & (bits >= ptr); if empty, pass 2 over unmasked req, lowest set bit.
//      In fixed mode, rr_pick returns the highest set bit.
//  - Top level: rr_pick instance, plus one always_ff holding idx, valid, ptr and grant_cnt
//    with async rst.
// TESTING
//  Defaults are WIDTH=4, CNT_W=8 unless stated. Compare every output after each edge.
//  1. Reset: rst=1 for 2 clk, then assert rst between edges during traffic.
//     -> idx=0, valid=0, grant_cnt=0 immediately; next grant after release behaves as from ptr=0.
//  2. Fixed mode, en=1:
//     - req=0001 -> idx=0, valid=1
//     - req=0011 -> idx=1
//     - req=1111 -> idx=3
//     - grant_cnt=3
//     - then req=0000 -> valid=0, idx stays 3, grant_cnt stays 3.
//  3. RR mode, ptr=0, req=1111 held 5 cycles -> idx = 0,1,2,3,0.
//     req=0101 for 3 cycles -> idx = 2,0,2 (ptr continues from 1).
//  4. RR wrap with WIDTH=5, req=10001 held 3 cycles from reset -> idx = 0,4,0.
//     ptr never reaches 5.
//  5. Controls:
//     - en=0 with req=1111 for 3 cycles -> all outputs and ptr hold.
//     - clr=1 with en=1, req=1111 -> idx=0, valid=0, grant_cnt=0, ptr=0.
//     - mode 1->0->1 mid-stream -> ptr is preserved.
//  6. Saturation, CNT_W=2: 6 consecutive grants -> grant_cnt = 1,2,3,3,3,3.

Source files
------------

// File: rtl/rr_enc_pkg.sv
// Shared types and helpers for the round-robin priority encoder.
package rr_enc_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  // Index width that stays at least one bit wide for degenerate widths.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational request picker: highest set bit in fixed mode, or a two-pass
// masked search starting at ptr_i in round-robin mode.
module rr_pick
  import rr_enc_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned IDX_W = clog2_min1(WIDTH)
) (
  input  logic [WIDTH-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  mode_e            mode_i,
  output logic [IDX_W-1:0] winner_o,
  output logic             any_o
);

  logic [WIDTH-1:0] masked;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_masked_idx;
  logic [IDX_W-1:0] lo_idx;

  always_comb begin
    masked = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      masked[i] = req_i[i] && (i >= int'(ptr_i));
    end
  end

  // Ascending loop: last hit wins, giving the highest set index.
  always_comb begin
    hi_idx = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (req_i[i]) hi_idx = IDX_W'(i);
    end
  end

  // Descending loops: last hit wins, giving the lowest set index.
  always_comb begin
    lo_masked_idx = '0;
    lo_idx        = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (masked[i]) lo_masked_idx = IDX_W'(i);
      if (req_i[i])  lo_idx        = IDX_W'(i);
    end
  end

  always_comb begin
    any_o = |req_i;
    if (mode_i == MODE_FIXED) begin
      winner_o = hi_idx;
    end else if (|masked) begin
      winner_o = lo_masked_idx;
    end else begin
      winner_o = lo_idx;
    end
  end

endmodule

// File: rtl/rr_priority_encoder.sv
// Registered priority encoder / request picker with fixed or round-robin
// selection and a saturating grant counter.
module rr_priority_encoder
  import rr_enc_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8,
  localparam int unsigned IDX_W = clog2_min1(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] grant_cnt_o
);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0] winner;
  logic             any;
  mode_e            mode;

  assign mode = mode_e'(mode_i);

  rr_pick #(
    .WIDTH(WIDTH),
    .IDX_W(IDX_W)
  ) u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .mode_i  (mode),
    .winner_o(winner),
    .any_o   (any)
  );

  always_comb begin
    idx_d   = idx_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      idx_d   = '0;
      valid_d = 1'b0;
      ptr_d   = '0;
      cnt_d   = '0;
    end else if (en_i) begin
      valid_d = any;
      if (any) begin
        idx_d = winner;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        if (mode == MODE_RR) begin
          // Explicit wrap so non-power-of-two widths never reach WIDTH.
          ptr_d = (winner == IDX_W'(WIDTH - 1)) ? '0 : winner + IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      idx_q   <= idx_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign idx_o       = idx_q;
  assign valid_o     = valid_q;
  assign grant_cnt_o = cnt_q;

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Directed bench: a 4-wide instance driven from a vector table, plus a 5-wide
// instance for wrap and a 2-bit-counter instance for saturation.
module tb_rr_priority_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       mode;
  logic       clr;
  logic [3:0] req4;
  logic [4:0] req5;

  logic [1:0] idx4;
  logic       valid4;
  logic [7:0] cnt4;
  logic [2:0] idx5;
  logic       valid5;
  logic [7:0] cnt5;
  logic [1:0] idxs;
  logic       valids;
  logic [1:0] cnts;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rr_priority_encoder #(.WIDTH(4), .CNT_W(8)) dut4 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .clr_i(clr), .req_i(req4),
    .idx_o(idx4), .valid_o(valid4), .grant_cnt_o(cnt4)
  );

  rr_priority_encoder #(.WIDTH(5), .CNT_W(8)) dut5 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .clr_i(clr), .req_i(req5),
    .idx_o(idx5), .valid_o(valid5), .grant_cnt_o(cnt5)
  );

  rr_priority_encoder #(.WIDTH(4), .CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .clr_i(clr), .req_i(req4),
    .idx_o(idxs), .valid_o(valids), .grant_cnt_o(cnts)
  );

  typedef struct {
    string      name;
    logic       en;
    logic       mode;
    logic       clr;
    logic [3:0] req;
    logic [1:0] idx;
    logic       valid;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string n, input logic e, input logic m, input logic c,
                              input logic [3:0] r, input logic [1:0] i, input logic v,
                              input logic [7:0] g);
    vec_t t;
    t.name = n; t.en = e; t.mode = m; t.clr = c; t.req = r;
    t.idx = i; t.valid = v; t.cnt = g;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic step(input logic e, input logic m, input logic c, input logic [3:0] r);
    en = e; mode = m; clr = c; req4 = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; clr = 1'b0; req4 = '0; req5 = '0;

    // Fixed mode, RR sequence, hold, mode switching, idle request, clear.
    vecs.push_back(mk("fix_0001", 1, 0, 0, 4'b0001, 0, 1, 1));
    vecs.push_back(mk("fix_0011", 1, 0, 0, 4'b0011, 1, 1, 2));
    vecs.push_back(mk("fix_1111", 1, 0, 0, 4'b1111, 3, 1, 3));
    vecs.push_back(mk("fix_0000", 1, 0, 0, 4'b0000, 3, 0, 3));
    vecs.push_back(mk("rr_a0",    1, 1, 0, 4'b1111, 0, 1, 4));
    vecs.push_back(mk("rr_a1",    1, 1, 0, 4'b1111, 1, 1, 5));
    vecs.push_back(mk("rr_a2",    1, 1, 0, 4'b1111, 2, 1, 6));
    vecs.push_back(mk("rr_a3",    1, 1, 0, 4'b1111, 3, 1, 7));
    vecs.push_back(mk("rr_a4",    1, 1, 0, 4'b1111, 0, 1, 8));
    vecs.push_back(mk("rr_b0",    1, 1, 0, 4'b0101, 2, 1, 9));
    vecs.push_back(mk("rr_b1",    1, 1, 0, 4'b0101, 0, 1, 10));
    vecs.push_back(mk("rr_b2",    1, 1, 0, 4'b0101, 2, 1, 11));
    vecs.push_back(mk("hold0",    0, 1, 0, 4'b1111, 2, 1, 11));
    vecs.push_back(mk("hold1",    0, 1, 0, 4'b1111, 2, 1, 11));
    vecs.push_back(mk("hold2",    0, 1, 0, 4'b1111, 2, 1, 11));
    vecs.push_back(mk("sw_fix",   1, 0, 0, 4'b0011, 1, 1, 12));
    vecs.push_back(mk("sw_rr0",   1, 1, 0, 4'b1111, 3, 1, 13));
    vecs.push_back(mk("sw_rr1",   1, 1, 0, 4'b1111, 0, 1, 14));
    vecs.push_back(mk("rr_none",  1, 1, 0, 4'b0000, 0, 0, 14));
    vecs.push_back(mk("rr_after", 1, 1, 0, 4'b1111, 1, 1, 15));
    vecs.push_back(mk("clr",      1, 1, 1, 4'b1111, 0, 0, 0));
    vecs.push_back(mk("post_clr", 1, 1, 0, 4'b1111, 0, 1, 1));
    vecs.push_back(mk("pre_rst",  1, 1, 0, 4'b1111, 1, 1, 2));

    // Reset held for two clocks.
    do_reset();
    chk("rst_idx", 32'(idx4), 0);
    chk("rst_valid", 32'(valid4), 0);
    chk("rst_cnt", 32'(cnt4), 0);

    foreach (vecs[k]) begin
      step(vecs[k].en, vecs[k].mode, vecs[k].clr, vecs[k].req);
      chk({vecs[k].name, "_idx"}, 32'(idx4), 32'(vecs[k].idx));
      chk({vecs[k].name, "_valid"}, 32'(valid4), 32'(vecs[k].valid));
      chk({vecs[k].name, "_cnt"}, 32'(cnt4), 32'(vecs[k].cnt));
    end

    // Asynchronous reset between edges; ptr is 2 at this point.
    #3;
    rst = 1'b1;
    #1;
    chk("async_idx", 32'(idx4), 0);
    chk("async_valid", 32'(valid4), 0);
    chk("async_cnt", 32'(cnt4), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1, 1, 0, 4'b1111);
    chk("rel_idx", 32'(idx4), 0);
    chk("rel_valid", 32'(valid4), 1);
    chk("rel_cnt", 32'(cnt4), 1);

    // Wrap on a non-power-of-two width.
    do_reset();
    req5 = 5'b10001;
    for (int k = 0; k < 5; k++) begin
      step(1, 1, 0, 4'b0000);
      chk($sformatf("wrap5_idx%0d", k), 32'(idx5), (k % 2 == 0) ? 0 : 4);
      chk($sformatf("wrap5_valid%0d", k), 32'(valid5), 1);
    end
    req5 = '0;

    // Saturation with a 2-bit counter.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(1, 0, 0, 4'b0001);
      chk($sformatf("sat_cnt%0d", k), 32'(cnts), (k < 3) ? k + 1 : 3);
    end
    step(0, 0, 1, 4'b0001);
    chk("sat_clr_cnt", 32'(cnts), 0);
    chk("sat_clr_valid", 32'(valids), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
